// File: rtl/data_mem_responder.sv
// Multi-channel data memory responder: round-robin arbitration over per-channel
// read/write requests into a single-port array, with fixed-latency ready pulses.
module data_mem_responder #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   host_write_enable,
  input  logic [ADDR_BITS-1:0]                   host_write_address,
  input  logic [DATA_BITS-1:0]                   host_write_data,
  input  logic [NUM_CHANNELS-1:0]                read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]                read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]                write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]                write_ready
);

  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned RrW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {StIdle, StPending, StRespond} state_e;

  state_e                                 state_q [NUM_CHANNELS];
  state_e                                 state_d [NUM_CHANNELS];
  logic   [CntW-1:0]                      cnt_q   [NUM_CHANNELS];
  logic   [CntW-1:0]                      cnt_d   [NUM_CHANNELS];
  logic   [NUM_CHANNELS-1:0]              kind_q, kind_d;  // 1 = write
  logic   [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
  logic   [NUM_CHANNELS-1:0]              rready_q, rready_d;
  logic   [NUM_CHANNELS-1:0]              wready_q, wready_d;
  logic   [RrW-1:0]                       rr_q, rr_d;
  logic   [DATA_BITS-1:0]                 mem_q [Depth];

  logic   [NUM_CHANNELS-1:0]              eligible;
  logic                                   gnt_valid;
  logic   [RrW-1:0]                       gnt_idx;
  logic                                   gnt_write;

  // First eligible channel at or after rr; host writes and reset suppress the grant.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = (state_q[i] == StIdle) && (read_valid[i] || write_valid[i]);
    end
    for (int unsigned off = 0; off < NUM_CHANNELS; off++) begin
      idx = (32'(rr_q) + off) % NUM_CHANNELS;
      if (!gnt_valid && eligible[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = RrW'(idx);
      end
    end
    if (!reset || host_write_enable) gnt_valid = 1'b0;
    gnt_write = !read_valid[gnt_idx];
    rr_d      = rr_q;
    if (gnt_valid) begin
      rr_d = (gnt_idx == RrW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    kind_d  = kind_q;
    rdata_d = rdata_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (gnt_valid && (gnt_idx == RrW'(i))) begin
            kind_d[i] = gnt_write;
            if (!gnt_write) rdata_d[i] = mem_q[read_address[i]];
            if (LATENCY == 1) begin
              state_d[i] = StRespond;
            end else begin
              state_d[i] = StPending;
              cnt_d[i]   = CntW'(LATENCY - 1);
            end
          end
        end
        StPending: begin
          if (cnt_q[i] <= CntW'(1)) begin
            state_d[i] = StRespond;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        StRespond: state_d[i] = StIdle;
        default:   state_d[i] = StIdle;
      endcase
      rready_d[i] = (state_d[i] == StRespond) && !kind_d[i];
      wready_d[i] = (state_d[i] == StRespond) && kind_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      kind_q   <= '0;
      rdata_q  <= '0;
      rready_q <= '0;
      wready_q <= '0;
      rr_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      kind_q   <= kind_d;
      rdata_q  <= rdata_d;
      rready_q <= rready_d;
      wready_q <= wready_d;
      rr_q     <= rr_d;
    end
  end

  // Array is deliberately not reset; granted writes survive a reset.
  always_ff @(posedge clk) begin
    if (host_write_enable) begin
      mem_q[host_write_address] <= host_write_data;
    end else if (gnt_valid && gnt_write) begin
      mem_q[write_address[gnt_idx]] <= write_data[gnt_idx];
    end
  end

  assign read_ready  = rready_q;
  assign write_ready = wready_q;
  assign read_data   = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected ready events are queued with their
// cycle and data, and every observed ready pulse is popped and compared.
module tb_data_mem_responder;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   host_write_enable = 1'b0;
  logic [AW-1:0]          host_write_address = '0;
  logic [DW-1:0]          host_write_data = '0;
  logic [NC-1:0]          read_valid = '0;
  logic [NC-1:0][AW-1:0]  read_address = '0;
  logic [NC-1:0]          read_ready;
  logic [NC-1:0][DW-1:0]  read_data;
  logic [NC-1:0]          write_valid = '0;
  logic [NC-1:0][AW-1:0]  write_address = '0;
  logic [NC-1:0][DW-1:0]  write_data = '0;
  logic [NC-1:0]          write_ready;

  data_mem_responder #(
    .ADDR_BITS   (AW),
    .DATA_BITS   (DW),
    .NUM_CHANNELS(NC),
    .LATENCY     (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .host_write_enable (host_write_enable),
    .host_write_address(host_write_address),
    .host_write_data   (host_write_data),
    .read_valid        (read_valid),
    .read_address      (read_address),
    .read_ready        (read_ready),
    .read_data         (read_data),
    .write_valid       (write_valid),
    .write_address     (write_address),
    .write_data        (write_data),
    .write_ready       (write_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  ch;
    logic        wr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  ev_t   exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string cur_test = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %h expected %h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input bit wr, input logic [7:0] data, input int ecyc);
    ev_t e;
    e.ch   = 8'(ch);
    e.wr   = wr;
    e.data = wr ? 8'h00 : data;
    e.cyc  = ecyc;
    exp_q.push_back(e);
  endtask

  // Compare one observed ready pulse against the oldest expectation; requester drops valid.
  task automatic handle(input int i, input bit wr);
    ev_t obs;
    ev_t exp;
    obs.ch   = 8'(i);
    obs.wr   = wr;
    obs.data = wr ? 8'h00 : read_data[i];
    obs.cyc  = cyc;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s/unexpected_ready: observed ch %0d wr %0d cycle %0d, expected no pulse",
             cur_test, i, wr, cyc);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("ready_event", 64'(obs), 64'(exp));
    end
    if (wr) write_valid[i] = 1'b0;
    else    read_valid[i]  = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (read_ready[i])  handle(i, 1'b0);
      if (write_ready[i]) handle(i, 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_write_enable  = 1'b1;
    host_write_address = a;
    host_write_data    = d;
    tick();
    host_write_enable  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s/drain_timeout: observed %0d pending events, expected 0",
             cur_test, exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 64'({read_ready, write_ready, read_data}), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    cur_test = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("outputs_in_reset");
    reset = 1'b1;

    cur_test = "single_read";
    host_wr(8'h10, 8'hA5);
    c = cyc;
    push(0, 1'b0, 8'hA5, c + 2);
    read_address[0] = 8'h10;
    read_valid[0]   = 1'b1;
    drain();
    check("data_held", 64'(read_data[0]), 64'(8'hA5));

    cur_test = "four_reads";
    reset = 1'b0;
    tick();
    check_reset_outputs("outputs_in_reset");
    tick();
    reset = 1'b1;
    for (int i = 0; i < NC; i++) host_wr(8'(i), 8'hC0 + 8'(i));
    c = cyc;
    for (int i = 0; i < NC; i++) begin
      push(i, 1'b0, 8'hC0 + 8'(i), c + 2 + i);
      read_address[i] = 8'(i);
    end
    read_valid = '1;
    drain();

    cur_test = "rr_wrapped";
    c = cyc;
    push(0, 1'b0, 8'hC1, c + 2);
    push(3, 1'b0, 8'hC2, c + 3);
    read_address[0] = 8'h01;
    read_address[3] = 8'h02;
    read_valid[0]   = 1'b1;
    read_valid[3]   = 1'b1;
    drain();

    cur_test = "write_then_read";
    c = cyc;
    push(1, 1'b1, 8'h00, c + 2);
    write_address[1] = 8'h20;
    write_data[1]    = 8'h3C;
    write_valid[1]   = 1'b1;
    drain();
    c = cyc;
    push(2, 1'b0, 8'h3C, c + 2);
    read_address[2] = 8'h20;
    read_valid[2]   = 1'b1;
    drain();

    cur_test = "read_and_write";
    host_wr(8'h05, 8'h5A);
    c = cyc;
    push(3, 1'b0, 8'h5A, c + 2);
    push(3, 1'b1, 8'h00, c + 5);
    read_address[3]  = 8'h05;
    write_address[3] = 8'h06;
    write_data[3]    = 8'h77;
    read_valid[3]    = 1'b1;
    write_valid[3]   = 1'b1;
    drain();
    c = cyc;
    push(0, 1'b0, 8'h77, c + 2);
    read_address[0] = 8'h06;
    read_valid[0]   = 1'b1;
    drain();

    cur_test = "host_collision";
    host_wr(8'h30, 8'hEE);
    c = cyc;
    push(0, 1'b0, 8'h11, c + 3);
    host_write_enable  = 1'b1;
    host_write_address = 8'h30;
    host_write_data    = 8'h11;
    read_address[0]    = 8'h30;
    read_valid[0]      = 1'b1;
    tick();
    host_write_enable  = 1'b0;
    drain();

    cur_test = "mid_reset";
    c = cyc;
    push(2, 1'b1, 8'h00, c + 2);
    write_address[2] = 8'h40;
    write_data[2]    = 8'h99;
    write_valid[2]   = 1'b1;
    drain();
    read_address[2] = 8'h40;
    read_valid[2]   = 1'b1;
    tick();
    reset         = 1'b0;
    read_valid[2] = 1'b0;
    #1;
    check_reset_outputs("outputs_after_assert");
    tick();
    check_reset_outputs("outputs_held");
    reset = 1'b1;
    repeat (4) tick();
    c = cyc;
    push(2, 1'b0, 8'h99, c + 2);
    read_valid[2] = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
